// File: rtl/pid_pkg.sv
// Shared types and constants for the sequenced PID engine.
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPT,
    S_MUL_P,
    S_MUL_I,
    S_MUL_D,
    S_OUT
  } pid_state_t;

  localparam int KP_RST = 2048;
  localparam int KI_RST = 512;
  localparam int KD_RST = 102;

  localparam int unsigned Q_FACTOR_DEF = 10;
  localparam int unsigned OUT_W        = 48;

  localparam logic [1:0] CFG_KP  = 2'd0;
  localparam logic [1:0] CFG_KI  = 2'd1;
  localparam logic [1:0] CFG_KD  = 2'd2;
  localparam logic [1:0] CFG_CLR = 2'd3;

endpackage

// File: rtl/pid_sat.sv
// Signed clamp of an IN_W value into [MIN_V, MAX_V], returned at OUT_W bits.
module pid_sat #(
  parameter int unsigned             IN_W  = 64,
  parameter int unsigned             OUT_W = 48,
  parameter logic signed [IN_W-1:0]  MAX_V = '0,
  parameter logic signed [IN_W-1:0]  MIN_V = '0
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_val
);

  always_comb begin
    o_val = i_val[OUT_W-1:0];
    if (i_val > MAX_V) begin
      o_val = MAX_V[OUT_W-1:0];
    end else if (i_val < MIN_V) begin
      o_val = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/pid_seq_engine.sv
// PID engine sharing one signed multiplier across P, I and D per error sample,
// with run-time gains, a 1-deep sample buffer and saturating integrator/output.
module pid_seq_engine
  import pid_pkg::*;
#(
  parameter int unsigned ERR_W     = 22,
  parameter int unsigned GAIN_W    = 22,
  parameter int unsigned ACC_W     = 64,
  parameter int unsigned Q_FACTOR  = Q_FACTOR_DEF,
  parameter longint      INT_LIMIT = 64'sd1 <<< 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cnn_valid,
  input  logic [47:0]              i_cnn_error,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_addr,
  input  logic [GAIN_W-1:0]        cfg_wdata,
  output logic                     o_busy,
  output logic                     o_overrun,
  output logic                     o_pid_valid,
  output logic signed [OUT_W-1:0]  o_pid_output
);

  localparam logic signed [ACC_W-1:0] INT_MAX = ACC_W'(INT_LIMIT);
  localparam logic signed [ACC_W-1:0] INT_MIN = -INT_MAX;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  pid_state_t r_state;
  pid_state_t w_next_state;

  logic signed [GAIN_W-1:0] r_kp_sh, r_ki_sh, r_kd_sh;
  logic signed [GAIN_W-1:0] r_kp, r_ki, r_kd;
  logic                     r_clr_req;

  logic signed [ACC_W-1:0] r_e, r_e_prev, r_integ, r_deriv, r_acc;
  logic                    r_buf_full;
  logic signed [ACC_W-1:0] r_buf;

  logic                    w_load, w_load_from_buf, w_buf_set, w_buf_clr, w_drop;
  logic signed [ACC_W-1:0] w_err_ext;
  logic                    w_unused_err_hi;

  logic signed [GAIN_W-1:0] w_mul_gain;
  logic signed [ACC_W-1:0]  w_mul_opnd, w_gain_ext, w_prod;
  logic signed [ACC_W-1:0]  w_integ_base, w_eprev_base, w_integ_sum, w_integ_sat;
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [OUT_W-1:0]  w_out_sat;
  logic                     w_clr_write;

  assign w_err_ext       = {{(ACC_W-ERR_W){i_cnn_error[ERR_W-1]}}, i_cnn_error[ERR_W-1:0]};
  assign w_unused_err_hi = ^i_cnn_error[47:ERR_W];
  assign w_clr_write     = cfg_we && (cfg_addr == CFG_CLR);

  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // OUT with an empty buffer takes an arriving sample straight in; the buffer
  // therefore never holds data while the engine is idle.
  always_comb begin
    w_next_state    = r_state;
    w_load          = 1'b0;
    w_load_from_buf = 1'b0;
    w_buf_set       = 1'b0;
    w_buf_clr       = 1'b0;
    w_drop          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_cnn_valid) begin
          w_load       = 1'b1;
          w_next_state = S_CAPT;
        end
      end
      S_CAPT:  w_next_state = S_MUL_P;
      S_MUL_P: w_next_state = S_MUL_I;
      S_MUL_I: w_next_state = S_MUL_D;
      S_MUL_D: w_next_state = S_OUT;
      S_OUT: begin
        if (r_buf_full) begin
          w_load          = 1'b1;
          w_load_from_buf = 1'b1;
          w_next_state    = S_CAPT;
          if (i_cnn_valid) w_buf_set = 1'b1;
          else             w_buf_clr = 1'b1;
        end else if (i_cnn_valid) begin
          w_load       = 1'b1;
          w_next_state = S_CAPT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    if (i_cnn_valid && (r_state inside {S_CAPT, S_MUL_P, S_MUL_I, S_MUL_D})) begin
      if (r_buf_full) w_drop    = 1'b1;
      else            w_buf_set = 1'b1;
    end
  end

  always_comb begin
    w_mul_gain = r_kp;
    w_mul_opnd = r_e;
    unique case (r_state)
      S_MUL_I: begin
        w_mul_gain = r_ki;
        w_mul_opnd = r_integ;
      end
      S_MUL_D: begin
        w_mul_gain = r_kd;
        w_mul_opnd = r_deriv;
      end
      default: ;
    endcase
  end

  assign w_gain_ext = {{(ACC_W-GAIN_W){w_mul_gain[GAIN_W-1]}}, w_mul_gain};
  assign w_prod     = w_gain_ext * w_mul_opnd;

  assign w_integ_base = r_clr_req ? '0 : r_integ;
  assign w_eprev_base = r_clr_req ? '0 : r_e_prev;
  assign w_integ_sum  = w_integ_base + r_e;
  assign w_shifted    = r_acc >>> Q_FACTOR;

  pid_sat #(
    .IN_W  (ACC_W),
    .OUT_W (ACC_W),
    .MAX_V (INT_MAX),
    .MIN_V (INT_MIN)
  ) u_sat_integ (
    .i_val (w_integ_sum),
    .o_val (w_integ_sat)
  );

  pid_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .MAX_V (OUT_MAX),
    .MIN_V (OUT_MIN)
  ) u_sat_out (
    .i_val (w_shifted),
    .o_val (w_out_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kp_sh      <= GAIN_W'(KP_RST);
      r_ki_sh      <= GAIN_W'(KI_RST);
      r_kd_sh      <= GAIN_W'(KD_RST);
      r_kp         <= GAIN_W'(KP_RST);
      r_ki         <= GAIN_W'(KI_RST);
      r_kd         <= GAIN_W'(KD_RST);
      r_clr_req    <= 1'b0;
      r_e          <= '0;
      r_e_prev     <= '0;
      r_integ      <= '0;
      r_deriv      <= '0;
      r_acc        <= '0;
      r_buf_full   <= 1'b0;
      r_buf        <= '0;
      o_overrun    <= 1'b0;
      o_pid_valid  <= 1'b0;
      o_pid_output <= '0;
    end else begin
      o_overrun   <= w_drop;
      o_pid_valid <= 1'b0;

      if (w_load) begin
        r_e  <= w_load_from_buf ? r_buf : w_err_ext;
        r_kp <= r_kp_sh;
        r_ki <= r_ki_sh;
        r_kd <= r_kd_sh;
      end

      if (w_buf_set) begin
        r_buf_full <= 1'b1;
        r_buf      <= w_err_ext;
      end else if (w_buf_clr) begin
        r_buf_full <= 1'b0;
      end

      unique case (r_state)
        S_CAPT: begin
          r_integ   <= w_integ_sat;
          r_deriv   <= r_e - w_eprev_base;
          r_e_prev  <= r_e;
          r_clr_req <= 1'b0;
        end
        S_MUL_P: r_acc <= w_prod;
        S_MUL_I: r_acc <= r_acc + w_prod;
        S_MUL_D: r_acc <= r_acc + w_prod;
        S_OUT: begin
          o_pid_output <= w_out_sat;
          o_pid_valid  <= 1'b1;
        end
        default: ;
      endcase

      // A clear written in the CAPT cycle itself survives for the next sample.
      if (cfg_we) begin
        case (cfg_addr)
          CFG_KP:  r_kp_sh <= cfg_wdata;
          CFG_KI:  r_ki_sh <= cfg_wdata;
          CFG_KD:  r_kd_sh <= cfg_wdata;
          default: r_clr_req <= w_clr_write;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pid_seq_engine.sv
// Randomized and directed bench for pid_seq_engine against a transaction-level PID model.
module tb_pid_seq_engine;

  localparam longint LIM  = 4096;
  localparam longint OMAX = (longint'(1) <<< 47) - 1;
  localparam longint OMIN = -(longint'(1) <<< 47);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                i_cnn_valid = 1'b0;
  logic [47:0]         i_cnn_error = '0;
  logic                cfg_we = 1'b0;
  logic [1:0]          cfg_addr = '0;
  logic [21:0]         cfg_wdata = '0;
  logic                o_busy, o_overrun, o_pid_valid;
  logic signed [47:0]  o_pid_output;

  pid_seq_engine #(
    .ERR_W     (22),
    .GAIN_W    (22),
    .ACC_W     (64),
    .Q_FACTOR  (10),
    .INT_LIMIT (LIM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cnn_valid  (i_cnn_valid),
    .i_cnn_error  (i_cnn_error),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun),
    .o_pid_valid  (o_pid_valid),
    .o_pid_output (o_pid_output)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_value(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  longint m_edge = 0;
  longint m_kp_sh, m_ki_sh, m_kd_sh, g_kp, g_ki, g_kd;
  longint m_integ, m_eprev, m_pend_out, m_last_out, m_out_edge, m_buf_e;
  bit     m_clr, m_active, m_buf_v, x_valid, x_ovr;

  longint obs_q[$];
  longint obs_edge[$];
  int     ovr_cnt = 0;

  function automatic longint sx22(input logic [21:0] x);
    logic signed [21:0] s;
    s = x;
    return longint'(s);
  endfunction

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic m_reset();
    m_kp_sh = 2048; m_ki_sh = 512; m_kd_sh = 102;
    m_integ = 0; m_eprev = 0; m_clr = 0;
    m_active = 0; m_buf_v = 0; m_buf_e = 0;
    m_last_out = 0; m_pend_out = 0;
    x_valid = 0; x_ovr = 0;
  endtask

  task automatic m_accept(input longint e);
    longint d, acc;
    if (m_clr) begin
      m_integ = 0;
      m_eprev = 0;
      m_clr   = 0;
    end
    d       = e - m_eprev;
    m_integ = clamp(m_integ + e, -LIM, LIM);
    m_eprev = e;
    acc        = g_kp * e + g_ki * m_integ + g_kd * d;
    m_pend_out = clamp(acc >>> 10, OMIN, OMAX);
    m_active   = 1;
    m_out_edge = m_edge + 5;
  endtask

  task automatic m_edge_update(input bit v, input logic [47:0] err, input bit we,
                               input logic [1:0] a, input logic [21:0] wd);
    longint ev;
    g_kp = m_kp_sh; g_ki = m_ki_sh; g_kd = m_kd_sh;
    if (we) begin
      case (a)
        2'd0:    m_kp_sh = sx22(wd);
        2'd1:    m_ki_sh = sx22(wd);
        2'd2:    m_kd_sh = sx22(wd);
        default: m_clr = 1;
      endcase
    end
    ev = sx22(err[21:0]);
    x_valid = 0;
    x_ovr   = 0;
    if (m_active && m_edge == m_out_edge) begin
      x_valid    = 1;
      m_last_out = m_pend_out;
      if (m_buf_v) begin
        m_accept(m_buf_e);
        if (v) m_buf_e = ev;
        else   m_buf_v = 0;
      end else if (v) begin
        m_accept(ev);
      end else begin
        m_active = 0;
      end
    end else if (m_active) begin
      if (v) begin
        if (m_buf_v) x_ovr = 1;
        else begin
          m_buf_v = 1;
          m_buf_e = ev;
        end
      end
    end else if (v) begin
      m_accept(ev);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [47:0] err, input bit we,
                      input logic [1:0] a, input logic [21:0] wd);
    rst = r; i_cnn_valid = v; i_cnn_error = err;
    cfg_we = we; cfg_addr = a; cfg_wdata = wd;
    @(posedge clk);
    m_edge++;
    if (r) m_reset();
    else   m_edge_update(v, err, we, a, wd);
    #1;
    check_value("valid",   o_pid_valid,  x_valid);
    check_value("overrun", o_overrun,    x_ovr);
    check_value("busy",    o_busy,       m_active);
    check_value("output",  o_pid_output, m_last_out);
    if (o_pid_valid) begin
      obs_q.push_back(longint'(o_pid_output));
      obs_edge.push_back(m_edge);
    end
    if (o_overrun) ovr_cnt++;
  endtask

  task automatic idle(input int k);
    repeat (k) step(0, 0, '0, 0, 2'd0, '0);
  endtask

  task automatic send(input logic [47:0] e);
    step(0, 1, e, 0, 2'd0, '0);
  endtask

  task automatic cfg(input logic [1:0] a, input logic [21:0] d);
    step(0, 0, '0, 1, a, d);
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, 2'd0, '0);
    obs_q.delete();
    obs_edge.delete();
    ovr_cnt = 0;
  endtask

  initial begin
    longint t0;
    logic [47:0] e_neg;
    m_reset();
    do_reset();
    do_reset();
    check_value("rst_out", o_pid_output, 0);
    check_value("rst_busy", o_busy, 0);

    // Single sample, default gains
    send(48'd1024);
    t0 = m_edge;
    idle(6);
    check_value("s1_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      check_value("s1_out", obs_q[0], 2662);
      check_value("s1_latency", obs_edge[0] - t0, 5);
    end
    send(48'd1024);
    idle(6);
    check_value("s2_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) check_value("s2_out", obs_q[1], 3072);

    // Negative error and ignored upper bits
    do_reset();
    e_neg = -48'sd512;
    send(e_neg);
    idle(6);
    if (obs_q.size() >= 1) check_value("neg_out", obs_q[0], -1331);
    else check_value("neg_count", obs_q.size(), 1);
    do_reset();
    send(48'h0000_0040_0400);
    idle(6);
    if (obs_q.size() >= 1) check_value("hi_bits_out", obs_q[0], 2662);
    else check_value("hi_bits_count", obs_q.size(), 1);

    // Back-to-back burst: accept, buffer, drop
    do_reset();
    send(48'd1024);
    send(48'd1024);
    send(48'd1024);
    check_value("burst_ovr_pulse", o_overrun, 1);
    idle(10);
    check_value("burst_count", obs_q.size(), 2);
    check_value("burst_ovr_cnt", ovr_cnt, 1);
    if (obs_q.size() == 2) begin
      check_value("burst_out0", obs_q[0], 2662);
      check_value("burst_out1", obs_q[1], 3072);
      check_value("burst_gap", obs_edge[1] - obs_edge[0], 5);
    end

    // Ki-only with integrator clamp at LIM
    do_reset();
    cfg(2'd0, '0);
    cfg(2'd2, '0);
    for (int i = 0; i < 3; i++) begin
      send(48'd2000);
      idle(6);
    end
    check_value("clamp_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check_value("clamp_out0", obs_q[0], 1000);
      check_value("clamp_out1", obs_q[1], 2000);
      check_value("clamp_out2", obs_q[2], 2048);
    end

    // Gain write mid-computation applies to the next sample; clear request
    do_reset();
    send(48'd1024);
    idle(2);
    cfg(2'd0, 22'd1024);
    idle(3);
    send(48'd1024);
    idle(6);
    cfg(2'd0, 22'd2048);
    cfg(2'd3, '0);
    send(48'd1024);
    idle(6);
    check_value("gain_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check_value("gain_old", obs_q[0], 2662);
      check_value("gain_new", obs_q[1], 2048);
      check_value("clr_out", obs_q[2], 2662);
    end

    // Reset during MUL_D aborts the sample
    do_reset();
    send(48'd1024);
    idle(3);
    do_reset();
    check_value("abort_valid", o_pid_valid, 0);
    check_value("abort_out", o_pid_output, 0);
    check_value("abort_busy", o_busy, 0);
    idle(6);
    check_value("abort_count", obs_q.size(), 0);

    // Randomized traffic with occasional gain writes, clears and resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit          r, v, we;
      logic [47:0] e;
      logic [1:0]  a;
      logic [21:0] wd;
      r  = ($urandom_range(0, 499) == 0);
      v  = ($urandom_range(0, 9) < 4);
      e  = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) e[47:0] = 48'($urandom_range(0, 4000)) - 48'd2000;
      we = ($urandom_range(0, 19) == 0);
      a  = 2'($urandom_range(0, 3));
      wd = 22'($urandom());
      step(r, v, e, we, a, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pid_seq_engine.md
Name: pid_seq_engine

Overview:
Sequenced PID engine that time-multiplexes one signed multiplier across the P, I and D terms for each CNN error sample. It sits between the CNN output stage and the actuator interface, in place of a fully parallel PID datapath. It adds run-time gain configuration, a 1-deep sample buffer with overrun flagging, and saturating integrator and output.

Parameters:
ERR_W, 22, signed error width taken from the low bits of i_cnn_error
GAIN_W, 22, signed gain width (Q12.10)
ACC_W, 64, integrator and accumulator width
Q_FACTOR, 10, fractional bits removed from the final sum
INT_LIMIT, 2**40, symmetric integrator clamp (±INT_LIMIT)

Ports:
clk  in  1  clock
rst  in  1  reset
i_cnn_valid  in  1  one sample per cycle while high
i_cnn_error  in  48  CNN error; only [ERR_W-1:0] is used, sign-extended
cfg_we  in  1  configuration write strobe
cfg_addr  in  2  0=Kp, 1=Ki, 2=Kd, 3=clear integrator and e_prev
cfg_wdata  in  GAIN_W  gain value; ignored for addr 3
o_busy  out  1  high in any state other than IDLE
o_overrun  out  1  1-cycle pulse when a sample is dropped
o_pid_valid  out  1  1-cycle pulse, result valid
o_pid_output  out  48  signed control output

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; integrator 0; e_prev 0; pending buffer empty; state IDLE.
- Shadow and active gains reset to Kp=2048, Ki=512, Kd=102.
- Reset asserted mid-operation aborts the computation with no o_pid_valid, and discards the pending sample.

FSM states: IDLE, CAPT, MUL_P, MUL_I, MUL_D, OUT.
- Accept edge (edge 0), IDLE with i_cnn_valid=1: latch e. Copy shadow gains to active gains, using pre-edge shadow values. Go to CAPT.
- Edge 1, CAPT:
  - deriv = e - e_prev
  - integ = sat(integ + e, ±INT_LIMIT)
  - e_prev <= e
  - go to MUL_P
- Edge 2, MUL_P: acc <= Kp*e.
- Edge 3, MUL_I: acc += Ki*integ.
- Edge 4, MUL_D: acc += Kd*deriv. Go to OUT.
- Edge 5, OUT:
  - o_pid_output <= sat48(acc >>> Q_FACTOR), arithmetic shift, truncating toward -inf
  - o_pid_valid <= 1 for exactly one cycle
  - if the pending buffer is full: load it as the new e (with gain copy), clear the buffer, go to CAPT
  - otherwise go to IDLE
- Latency: o_pid_valid is high in the cycle after edge 5, i.e. 5 cycles after the accept edge. Maximum throughput is 1 sample per 5 cycles.
- Multiplier use: exactly one product per MUL_* state. Product is GAIN_W x ACC_W, truncated to ACC_W. The integrator clamp keeps this product in range.

Input buffering:
- i_cnn_valid=1 while not in IDLE with the buffer empty: the sample goes into the buffer.
- Buffer full, and not OUT consuming it that cycle: the sample is dropped and o_overrun pulses.
- In OUT, the buffer is consumed first, and an arriving sample then refills it.

Configuration:
- cfg writes update shadow gains immediately. They reach the datapath only at the next sample load.
- A write in the same cycle as an accept affects the following sample, not this one.
- addr 3 sets a clear-request flag. The clear is applied at the next CAPT, before the integrator update: integ := 0 and e_prev := 0, then the normal update proceeds. The flag is then cleared.

Decomposition:
- Shared package pid_pkg holds:
  - state enum
  - reset gain constants KP_RST, KI_RST, KD_RST
  - Q_FACTOR default
  - cfg address constants CFG_KP, CFG_KI, CFG_KD, CFG_CLR
- One sub-module, pid_sat: parameterised signed saturate/clamp. It is instantiated for the integrator (±INT_LIMIT) and for the 48-bit output.

Test Plan:
- Reset then one sample e=1024, default gains -> o_pid_valid exactly 5 cycles after accept, output 2662 (P=2097152, I=524288, D=104448, sum>>>10).
- Second sample e=1024 after the first completes -> integ=2048, deriv=0, output 3072.
- After reset, e=-512 -> output -1331. Also drive i_cnn_error=48'h0000_0040_0400 -> upper bits ignored, identical to the e=1024 case (2662).
- i_cnn_valid high for 3 consecutive cycles from IDLE with e=1024 each -> 1st accepted, 2nd buffered, 3rd dropped with o_overrun pulse on that cycle. Exactly two o_pid_valid pulses, 5 cycles apart: 2662, then 3072.
- INT_LIMIT=4096, Ki-only config (write Kp=0, Kd=0), e=2000 three times -> integ 2000, 4000, 4096. Outputs 1000, 2000, 2048.
- cfg write Kp=1024 during MUL_I of sample A -> A uses Kp=2048, next sample uses 1024. Write addr 3 then send e=1024 -> output equals the post-reset value 2662. Assert rst during MUL_D -> no o_pid_valid, all outputs 0 the next cycle.
